// File: rtl/mmio_fabric_pkg.sv
// Shared types and constants for the MMIO fabric.
package mmio_fabric_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_SLV,
        S_RESP,
        S_HOLD
    } state_t;

    localparam int          SLOT_W         = 4;
    localparam int          OFF_ERR_STATUS = 0;
    localparam int          OFF_ERR_ADDR   = 2;
    localparam logic [15:0] TO_DATA        = 16'hDEAD;

endpackage

// File: rtl/mmio_decoder.sv
// Combinational address decoder: memory, slave slot, internal regs or error.
module mmio_decoder
    import mmio_fabric_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                NSLV      = 4,
    parameter int                SLV_AW    = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hF000,
    parameter int                MMIO_SPAN = 256
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_is_mem,
    output logic              o_is_slv,
    output logic              o_is_int,
    output logic              o_is_err,
    output logic [SLOT_W-1:0] o_slot
);

    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_slotf;
    logic              w_in;
    logic              w_hi;

    assign w_off   = i_addr - MMIO_BASE;
    assign w_slotf = w_off >> SLV_AW;
    assign w_in    = (i_addr >= MMIO_BASE) && (32'(w_off) < MMIO_SPAN);
    // Any slot bit above SLOT_W means far past the last slave.
    assign w_hi    = |w_slotf[ADDR_W-1:SLOT_W];

    assign o_slot   = w_slotf[SLOT_W-1:0];
    assign o_is_mem = !w_in;
    assign o_is_slv = w_in && !w_hi && (o_slot < SLOT_W'(NSLV));
    assign o_is_int = w_in && !w_hi && (o_slot == SLOT_W'(NSLV));
    assign o_is_err = w_in && !o_is_slv && !o_is_int;

endmodule

// File: rtl/mmio_fabric.sv
// CPU-to-memory/MMIO fabric with request FSM, watchdog and error log.
module mmio_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                NSLV      = 4,
    parameter int                SLV_AW    = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hF000,
    parameter int                MMIO_SPAN = 256,
    parameter int                TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      cpu_mem_addr,
    input  logic [DATA_W-1:0]      cpu_mem_data_out,
    input  logic                   cpu_mem_write,
    input  logic                   cpu_mem_read,
    input  logic                   cpu_mem_req,
    output logic [DATA_W-1:0]      cpu_mem_data_in,
    output logic                   cpu_mem_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic [NSLV-1:0]        slv_sel,
    output logic                   slv_we,
    output logic [SLV_AW-1:0]      slv_addr,
    output logic [DATA_W-1:0]      slv_wdata,
    input  logic [NSLV*DATA_W-1:0] slv_rdata,
    input  logic [NSLV-1:0]        slv_ack,
    output logic                   bus_err
);

    state_t              r_state, w_state_n;
    logic [ADDR_W-1:0]   r_addr, r_err_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic                r_we, r_mem_req, r_ready, r_berr;
    logic [NSLV-1:0]     r_sel, w_onehot;
    logic [7:0]          r_wdog, w_wd_inc;
    logic [15:0]         r_err_status, w_stat_n;
    logic                w_is_mem, w_is_slv, w_is_int, w_is_err;
    logic [SLOT_W-1:0]   w_slot;
    logic                w_accept, w_wr, w_hit, w_to, w_derr, w_clr;
    logic [SLV_AW-1:0]   w_off_lo;
    logic [DATA_W-1:0]   w_int_rd, w_srd;

    mmio_decoder #(
        .ADDR_W    (ADDR_W),
        .NSLV      (NSLV),
        .SLV_AW    (SLV_AW),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_SPAN (MMIO_SPAN)
    ) u_dec (
        .i_addr   (cpu_mem_addr),
        .o_is_mem (w_is_mem),
        .o_is_slv (w_is_slv),
        .o_is_int (w_is_int),
        .o_is_err (w_is_err),
        .o_slot   (w_slot)
    );

    assign w_wr     = cpu_mem_write && !cpu_mem_read;
    assign w_accept = (r_state == S_IDLE) && cpu_mem_req;
    assign w_off_lo = cpu_mem_addr[SLV_AW-1:0];
    assign w_wd_inc = r_wdog + 8'd1;
    assign w_hit    = ((r_state == S_MEM) && mem_ready) ||
                      ((r_state == S_SLV) && |(slv_ack & r_sel));
    // Ack in the final watchdog cycle still completes normally.
    assign w_to     = ((r_state == S_MEM) || (r_state == S_SLV)) &&
                      !w_hit && (w_wd_inc >= 8'(TIMEOUT));
    assign w_derr   = w_accept && w_is_err;
    assign w_clr    = w_accept && w_is_int && w_wr &&
                      (w_off_lo == SLV_AW'(OFF_ERR_STATUS));

    always_comb begin
        w_onehot = '0;
        w_srd    = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_onehot[i] = (w_slot == SLOT_W'(i));
            if (r_sel[i]) w_srd = w_srd | slv_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_int_rd = '0;
        if (w_off_lo == SLV_AW'(OFF_ERR_STATUS))
            w_int_rd = DATA_W'(r_err_status);
        else if (w_off_lo == SLV_AW'(OFF_ERR_ADDR))
            w_int_rd = DATA_W'(r_err_addr);
    end

    // Clear first so a coincident error leaves a count of one.
    always_comb begin
        w_stat_n = w_clr ? 16'h0 : r_err_status;
        if (w_to)   w_stat_n[0] = 1'b1;
        if (w_derr) w_stat_n[1] = 1'b1;
        if ((w_to || w_derr) && (w_stat_n[15:8] != 8'hFF))
            w_stat_n[15:8] = w_stat_n[15:8] + 8'd1;
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept) begin
                    unique case (1'b1)
                        w_is_mem: w_state_n = S_MEM;
                        w_is_slv: w_state_n = S_SLV;
                        default:  w_state_n = S_RESP;
                    endcase
                end
            S_MEM, S_SLV:
                if (w_hit || w_to) w_state_n = S_RESP;
            S_RESP:
                w_state_n = S_HOLD;
            S_HOLD:
                if (!cpu_mem_req) w_state_n = S_IDLE;
            default:
                w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_rdata   <= '0;
            r_mem_req <= 1'b0;
            r_sel     <= '0;
            r_ready   <= 1'b0;
            r_berr    <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_ready <= 1'b0;
            r_berr  <= 1'b0;
            if (w_accept) begin
                r_addr  <= cpu_mem_addr;
                r_wdata <= cpu_mem_data_out;
                r_we    <= w_wr;
                r_wdog  <= '0;
                if (w_is_mem) r_mem_req <= 1'b1;
                if (w_is_slv) r_sel <= w_onehot;
                if (w_is_int) begin
                    r_ready <= 1'b1;
                    r_rdata <= w_wr ? '0 : w_int_rd;
                end
                if (w_is_err) begin
                    r_ready <= 1'b1;
                    r_berr  <= 1'b1;
                    r_rdata <= '0;
                end
            end
            if (w_hit) begin
                r_ready   <= 1'b1;
                r_rdata   <= (r_state == S_MEM) ? mem_rdata : w_srd;
                r_mem_req <= 1'b0;
                r_sel     <= '0;
            end else if (w_to) begin
                r_ready   <= 1'b1;
                r_berr    <= 1'b1;
                r_rdata   <= DATA_W'(TO_DATA);
                r_mem_req <= 1'b0;
                r_sel     <= '0;
            end else if ((r_state == S_MEM) || (r_state == S_SLV)) begin
                r_wdog <= w_wd_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_status <= '0;
            r_err_addr   <= '0;
        end else begin
            r_err_status <= w_stat_n;
            if (w_to)        r_err_addr <= r_addr;
            else if (w_derr) r_err_addr <= cpu_mem_addr;
        end
    end

    assign cpu_mem_data_in = r_rdata;
    assign cpu_mem_ready   = r_ready;
    assign bus_err         = r_berr;
    assign mem_req         = r_mem_req;
    assign mem_we          = r_we;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign slv_sel         = r_sel;
    assign slv_we          = r_we;
    assign slv_addr        = r_addr[SLV_AW-1:0];
    assign slv_wdata       = r_wdata;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed self-checking bench for mmio_fabric.
module tb_mmio_fabric;

    logic        clk;
    logic        reset_n;
    logic [15:0] cpu_mem_addr;
    logic [15:0] cpu_mem_data_out;
    logic        cpu_mem_write;
    logic        cpu_mem_read;
    logic        cpu_mem_req;
    logic [15:0] cpu_mem_data_in;
    logic        cpu_mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [3:0]  slv_sel;
    logic        slv_we;
    logic [3:0]  slv_addr;
    logic [15:0] slv_wdata;
    logic [63:0] slv_rdata;
    logic [3:0]  slv_ack;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_rdy;

    mmio_fabric dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_mem_addr     (cpu_mem_addr),
        .cpu_mem_data_out (cpu_mem_data_out),
        .cpu_mem_write    (cpu_mem_write),
        .cpu_mem_read     (cpu_mem_read),
        .cpu_mem_req      (cpu_mem_req),
        .cpu_mem_data_in  (cpu_mem_data_in),
        .cpu_mem_ready    (cpu_mem_ready),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .slv_sel          (slv_sel),
        .slv_we           (slv_we),
        .slv_addr         (slv_addr),
        .slv_wdata        (slv_wdata),
        .slv_rdata        (slv_rdata),
        .slv_ack          (slv_ack),
        .bus_err          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic wr,
                         input logic [15:0] d);
        cpu_mem_addr     = a;
        cpu_mem_write    = wr;
        cpu_mem_read     = !wr;
        cpu_mem_data_out = d;
        cpu_mem_req      = 1'b1;
    endtask

    task automatic done();
        cpu_mem_req   = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_mem_read  = 1'b0;
        tick();
        tick();
    endtask

    // Internal-register read: ready and data in cycle 1.
    task automatic rd_int(input string tag, input logic [15:0] a,
                          input logic [15:0] exp);
        start(a, 1'b0, 16'h0);
        tick();
        chk({tag, "_rdy"}, 32'(cpu_mem_ready), 32'd1);
        chk({tag, "_dat"}, 32'(cpu_mem_data_in), 32'(exp));
        done();
    endtask

    initial begin
        reset_n          = 1'b0;
        cpu_mem_addr     = '0;
        cpu_mem_data_out = '0;
        cpu_mem_write    = 1'b0;
        cpu_mem_read     = 1'b0;
        cpu_mem_req      = 1'b0;
        mem_rdata        = '0;
        mem_ready        = 1'b0;
        slv_ack          = '0;
        slv_rdata        = {16'h5A03, 16'h5A02, 16'h5A01, 16'h5A00};
        tick();
        tick();
        chk("rst_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rst_data", 32'(cpu_mem_data_in), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_memaddr", 32'(mem_addr), 32'd0);
        chk("rst_sel", 32'(slv_sel), 32'd0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // memory read, ready three cycles after mem_req rises
        start(16'h1234, 1'b0, 16'h0);
        tick();
        chk("mem_req_c1", 32'(mem_req), 32'd1);
        chk("mem_addr", 32'(mem_addr), 32'h1234);
        chk("mem_we", 32'(mem_we), 32'd0);
        tick();
        tick();
        chk("mem_req_c3", 32'(mem_req), 32'd1);
        chk("mem_nordy_c3", 32'(cpu_mem_ready), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        chk("mem_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("mem_data", 32'(cpu_mem_data_in), 32'hBEEF);
        chk("mem_req_drop", 32'(mem_req), 32'd0);
        chk("mem_berr", 32'(bus_err), 32'd0);
        mem_ready = 1'b0;
        done();
        chk("mem_rdy_pulse", 32'(cpu_mem_ready), 32'd0);

        // zero-wait slave write to slave 2 offset 4
        start(16'hF024, 1'b1, 16'h00A5);
        tick();
        chk("sw_sel", 32'(slv_sel), 32'b0100);
        chk("sw_we", 32'(slv_we), 32'd1);
        chk("sw_addr", 32'(slv_addr), 32'd4);
        chk("sw_wdata", 32'(slv_wdata), 32'h00A5);
        slv_ack = 4'b0100;
        tick();
        chk("sw_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("sw_berr", 32'(bus_err), 32'd0);
        chk("sw_sel_drop", 32'(slv_sel), 32'd0);
        slv_ack = '0;
        done();

        // slave 3 read, ack in cycle 2
        start(16'hF030, 1'b0, 16'h0);
        tick();
        chk("sr_sel", 32'(slv_sel), 32'b1000);
        tick();
        slv_ack = 4'b1000;
        tick();
        chk("sr_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("sr_data", 32'(cpu_mem_data_in), 32'h5A03);
        slv_ack = '0;
        done();

        // slave 1 never acks; other slaves' acks must be ignored
        start(16'hF010, 1'b0, 16'h0);
        tick();
        chk("to_sel_c1", 32'(slv_sel), 32'b0010);
        slv_ack = 4'b1101;
        repeat (14) tick();
        chk("to_sel_c15", 32'(slv_sel), 32'b0010);
        chk("to_nordy_c15", 32'(cpu_mem_ready), 32'd0);
        tick();
        chk("to_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("to_data", 32'(cpu_mem_data_in), 32'hDEAD);
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_sel_drop", 32'(slv_sel), 32'd0);
        slv_ack = '0;
        cpu_mem_req = 1'b0;
        tick();
        chk("to_berr_pulse", 32'(bus_err), 32'd0);
        tick();
        rd_int("to_stat", 16'hF040, 16'h0101);
        rd_int("to_eaddr", 16'hF042, 16'hF010);

        // clear, then decode error
        start(16'hF040, 1'b1, 16'h1234);
        tick();
        chk("clr_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("clr_berr", 32'(bus_err), 32'd0);
        done();
        rd_int("clr_stat", 16'hF040, 16'h0000);
        start(16'hF050, 1'b0, 16'h0);
        tick();
        chk("de_rdy", 32'(cpu_mem_ready), 32'd1);
        chk("de_data", 32'(cpu_mem_data_in), 32'h0000);
        chk("de_berr", 32'(bus_err), 32'd1);
        done();
        rd_int("de_stat", 16'hF040, 16'h0102);
        rd_int("de_eaddr", 16'hF042, 16'hF050);
        rd_int("int_other", 16'hF044, 16'h0000);
        start(16'hF040, 1'b1, 16'h0);
        tick();
        done();
        rd_int("de_clr", 16'hF040, 16'h0000);
        start(16'hF0F0, 1'b0, 16'h0);
        tick();
        chk("de2_berr", 32'(bus_err), 32'd1);
        done();
        rd_int("de2_stat", 16'hF040, 16'h0102);

        // req held high: exactly one transaction, then re-arm
        mem_ready = 1'b1;
        mem_rdata = 16'h4321;
        start(16'h0100, 1'b0, 16'h0);
        n_rdy = 0;
        repeat (12) begin
            tick();
            if (cpu_mem_ready) n_rdy++;
        end
        chk("hold_one", 32'(n_rdy), 32'd1);
        cpu_mem_req = 1'b0;
        tick();
        cpu_mem_req = 1'b1;
        n_rdy = 0;
        repeat (5) begin
            tick();
            if (cpu_mem_ready) n_rdy++;
        end
        chk("rearm_one", 32'(n_rdy), 32'd1);
        chk("rearm_data", 32'(cpu_mem_data_in), 32'h4321);
        mem_ready = 1'b0;
        done();

        // reset during a slave access
        start(16'hF000, 1'b0, 16'h0);
        tick();
        chk("rs_sel", 32'(slv_sel), 32'b0001);
        reset_n = 1'b0;
        #1;
        chk("rs_sel_drop", 32'(slv_sel), 32'd0);
        cpu_mem_req = 1'b0;
        n_rdy = 0;
        repeat (3) begin
            tick();
            if (cpu_mem_ready) n_rdy++;
        end
        chk("rs_no_rdy", 32'(n_rdy), 32'd0);
        reset_n = 1'b1;
        tick();
        rd_int("rs_stat", 16'hF040, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
